// File: rtl/hpdmc_datactl_if.sv
// Command-side bundle between the command FSM and the data-timing controller.
// The FSM drives the strobes and timings; the controller returns the safe flags and data-path controls.
interface hpdmc_datactl_if;
   logic       read;
   logic       write;
   logic [3:0] concerned_bank;
   logic       tim_cas;
   logic [1:0] tim_wr;
   logic       read_safe;
   logic       write_safe;
   logic [3:0] precharge_safe;
   logic       direction;
   logic       direction_r;
   logic       data_capture;

   modport master (
      output read, write, concerned_bank, tim_cas, tim_wr,
      input  read_safe, write_safe, precharge_safe, direction, direction_r, data_capture
   );

   modport slave (
      input  read, write, concerned_bank, tim_cas, tim_wr,
      output read_safe, write_safe, precharge_safe, direction, direction_r, data_capture
   );
endinterface

// File: rtl/hpdmc_datactl.sv
// DDR timing-safety counters and DQ direction / read-capture sequencing.
// Every output comes straight from a register, so nothing responds in the same cycle as a command.
module hpdmc_datactl (
   input  logic           sys_clk,
   input  logic           sdram_rst,
   hpdmc_datactl_if.slave ctl
);

   logic [2:0] read_cnt_q, read_cnt_d;
   logic [2:0] write_cnt_q, write_cnt_d;
   logic [2:0] pre_cnt_q [4];
   logic [2:0] pre_cnt_d [4];
   logic [4:0] cap_q, cap_d;
   logic [1:0] dir_q, dir_d;
   logic       dir_r_q;

   logic       rd_ev;
   logic       wr_ev;
   logic       any_ev;
   logic [2:0] cl_load;
   logic [2:0] wr_load;

   // Decrement toward zero, but an event may only extend the pending restriction.
   function automatic logic [2:0] reload(input logic [2:0] cnt, input logic [2:0] ld,
                                         input logic en);
      logic [2:0] dec;
      dec = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
      return (en && (ld > dec)) ? ld : dec;
   endfunction

   always_comb begin
      // A simultaneous read and write is treated as a write only.
      rd_ev   = ctl.read & ~ctl.write;
      wr_ev   = ctl.write;
      any_ev  = rd_ev | wr_ev;
      cl_load = ctl.tim_cas ? 3'd5 : 3'd4;
      wr_load = 3'd2 + {1'b0, ctl.tim_wr};

      read_cnt_d  = reload(read_cnt_q, wr_ev ? wr_load : 3'd1, any_ev);
      write_cnt_d = reload(write_cnt_q, wr_ev ? 3'd1 : cl_load, any_ev);
      for (int b = 0; b < 4; b++) begin
         pre_cnt_d[b] = reload(pre_cnt_q[b], wr_ev ? wr_load : 3'd1,
                               any_ev & ctl.concerned_bank[b]);
      end

      // Bit k of the capture line is data_capture k+1 cycles after the read.
      cap_d = {1'b0, cap_q[4:1]};
      if (rd_ev) cap_d = cap_d | (ctl.tim_cas ? 5'b11000 : 5'b01100);

      dir_d = {1'b0, dir_q[1]};
      if (wr_ev) dir_d = 2'b11;
   end

   always_ff @(posedge sys_clk) begin
      if (sdram_rst) begin
         read_cnt_q  <= 3'd0;
         write_cnt_q <= 3'd0;
         for (int b = 0; b < 4; b++) pre_cnt_q[b] <= 3'd0;
         cap_q       <= 5'd0;
         dir_q       <= 2'd0;
         dir_r_q     <= 1'b0;
      end else begin
         read_cnt_q  <= read_cnt_d;
         write_cnt_q <= write_cnt_d;
         for (int b = 0; b < 4; b++) pre_cnt_q[b] <= pre_cnt_d[b];
         cap_q       <= cap_d;
         dir_q       <= dir_d;
         dir_r_q     <= dir_q[0];
      end
   end

   assign ctl.read_safe    = (read_cnt_q == 3'd0);
   assign ctl.write_safe   = (write_cnt_q == 3'd0);
   assign ctl.direction    = dir_q[0];
   assign ctl.direction_r  = dir_r_q;
   assign ctl.data_capture = cap_q[0];

   for (genvar g = 0; g < 4; g++) begin : g_pre_safe
      assign ctl.precharge_safe[g] = (pre_cnt_q[g] == 3'd0);
   end

endmodule
